// File: rtl/ub_bcl_sub_9_17.sv
// Pipelined 17-bit subtractor D = Y - {8'b0, X} with two-level block carry look-ahead.
// Optional zero flag output ZF is enabled by defining UB_BCL_SUB_ZFLAG_EN.
module ub_bcl_sub_9_17 (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  X,
    input  logic [16:0] Y,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] D,
    output logic        BO,
`ifdef UB_BCL_SUB_ZFLAG_EN
    output logic        ZF,
`endif
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned W  = 17;
    localparam int unsigned NB = 5;

    logic en;

    // stage 1 state: per-bit generate/propagate and block G/P
    logic          v1;
    logic [W-1:0]  s1_g, s1_p;
    logic [NB-1:0] s1_bg, s1_bp;

    // stage 2 state: block carry-ins and final carry
    logic          v2;
    logic [W-1:0]  s2_g, s2_p;
    logic [NB-1:0] s2_c1;
    logic          s2_cout;

    logic [W-1:0]  z, g0, p0;
    logic [NB-1:0] bg, bp;
    logic [NB-1:0] c1;
    logic          cout;
    logic [W-1:0]  c, sum;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // first level: bitwise terms and group terms for 4-bit blocks plus the lone top bit
    always_comb begin
        z  = W'(X);
        g0 = Y & ~z;
        p0 = Y ^ ~z;
        bg = '0;
        bp = '0;
        for (int b = 0; b < 4; b++) begin
            bg[b] = g0[4*b+3]
                  | (p0[4*b+3] & g0[4*b+2])
                  | (p0[4*b+3] & p0[4*b+2] & g0[4*b+1])
                  | (p0[4*b+3] & p0[4*b+2] & p0[4*b+1] & g0[4*b]);
            bp[b] = &p0[4*b +: 4];
        end
        bg[4] = g0[16];
        bp[4] = p0[16];
    end

    // second level look-ahead over the four 4-bit blocks; carry-in is 1
    always_comb begin
        c1    = '0;
        c1[0] = 1'b1;
        c1[1] = s1_bg[0] | s1_bp[0];
        c1[2] = s1_bg[1] | (s1_bp[1] & s1_bg[0]) | (s1_bp[1] & s1_bp[0]);
        c1[3] = s1_bg[2] | (s1_bp[2] & s1_bg[1]) | (s1_bp[2] & s1_bp[1] & s1_bg[0])
              | (s1_bp[2] & s1_bp[1] & s1_bp[0]);
        c1[4] = s1_bg[3] | (s1_bp[3] & s1_bg[2]) | (s1_bp[3] & s1_bp[2] & s1_bg[1])
              | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bg[0])
              | (&s1_bp[3:0]);
        cout  = s1_bg[4] | (s1_bp[4] & c1[4]);
    end

    // in-block carries seeded from the registered block carry-ins
    always_comb begin
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (i % 4 == 0) c[i] = s2_c1[3'(i / 4)];
            else            c[i] = s2_g[i-1] | (s2_p[i-1] & c[i-1]);
        end
        sum = s2_p ^ c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_g      <= '0;
            s1_p      <= '0;
            s1_bg     <= '0;
            s1_bp     <= '0;
            v2        <= 1'b0;
            s2_g      <= '0;
            s2_p      <= '0;
            s2_c1     <= '0;
            s2_cout   <= 1'b0;
            out_valid <= 1'b0;
            D         <= '0;
            BO        <= 1'b0;
`ifdef UB_BCL_SUB_ZFLAG_EN
            ZF        <= 1'b0;
`endif
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_g  <= g0;
                s1_p  <= p0;
                s1_bg <= bg;
                s1_bp <= bp;
            end
            v2 <= v1;
            if (v1) begin
                s2_g    <= s1_g;
                s2_p    <= s1_p;
                s2_c1   <= c1;
                s2_cout <= cout;
            end
            out_valid <= v2;
            if (v2) begin
                D  <= sum;
                BO <= ~s2_cout;
`ifdef UB_BCL_SUB_ZFLAG_EN
                ZF <= (sum == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_ub_bcl_sub_9_17.sv
// Self-checking bench for ub_bcl_sub_9_17: directed and random operands against an
// arithmetic reference, with a scoreboard queue for ordering, stall and reset behaviour.
module tb_ub_bcl_sub_9_17;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  X;
    logic [16:0] Y;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] D;
    logic        BO;
    logic        out_valid;
    logic        out_ready;
`ifdef UB_BCL_SUB_ZFLAG_EN
    logic        ZF;
`endif

    int errors = 0;
    int checks = 0;
    logic [17:0] q[$];   // expected {BO, D} in acceptance order

    ub_bcl_sub_9_17 dut (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .in_valid(in_valid), .in_ready(in_ready),
        .D(D), .BO(BO),
`ifdef UB_BCL_SUB_ZFLAG_EN
        .ZF(ZF),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 18-bit difference; bit 17 is the borrow (Y < X)
    function automatic logic [17:0] ref_sub(input logic [8:0] x, input logic [16:0] y);
        logic [17:0] r;
        r = {1'b0, y} - 18'(x);
        return r;
    endfunction

    // One cycle: drive, scoreboard at the falling edge, then advance past the rising edge
    task automatic cyc(input logic iv, input logic [8:0] x, input logic [16:0] y,
                       input logic ordy);
        logic [17:0] e;
        in_valid  = iv;
        X         = x;
        Y         = y;
        out_ready = ordy;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("out_expected", 18'(q.size() > 0), 18'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("D", 18'(D), 18'(e[16:0]));
                chk("BO", 18'(BO), 18'(e[17]));
`ifdef UB_BCL_SUB_ZFLAG_EN
                chk("ZF", 18'(ZF), 18'(e[16:0] == 17'd0));
`endif
            end
        end
        if (iv && in_ready) q.push_back(ref_sub(x, y));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && q.size() > 0; k++) cyc(1'b0, 9'd0, 17'd0, 1'b1);
        chk(tag, 18'(q.size()), 18'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 18'(out_valid), 18'd0);
        chk("rst_D", 18'(D), 18'd0);
        chk("rst_BO", 18'(BO), 18'd0);
        chk("rst_in_ready", 18'(in_ready), 18'd1);
        rst = 1'b0;

        // basic case and three-cycle latency
        cyc(1'b1, 9'h005, 17'h00012, 1'b1);
        chk("lat1_out_valid", 18'(out_valid), 18'd0);
        cyc(1'b0, 9'd0, 17'd0, 1'b1);
        chk("lat2_out_valid", 18'(out_valid), 18'd0);
        cyc(1'b0, 9'd0, 17'd0, 1'b1);
        chk("lat3_out_valid", 18'(out_valid), 18'd1);
        chk("lat3_D", 18'(D), 18'h0000D);
        chk("lat3_BO", 18'(BO), 18'd0);
        drain("drain_basic");

        // extremes and block-boundary borrow chains
        cyc(1'b1, 9'h1FF, 17'h00000, 1'b1);
        cyc(1'b1, 9'h1FF, 17'h001FF, 1'b1);
        cyc(1'b1, 9'h001, 17'h10000, 1'b1);
        cyc(1'b1, 9'h001, 17'h00100, 1'b1);
        cyc(1'b1, 9'h001, 17'h00010, 1'b1);
        cyc(1'b1, 9'h000, 17'h1FFFF, 1'b1);
        drain("drain_edges");
        chk("edge_ref_a", ref_sub(9'h1FF, 17'h0), {1'b1, 17'h1FE01});

        // back-to-back random stream: exactly 3 drain cycles proves one result per cycle
        for (int n = 0; n < 100; n++) cyc(1'b1, 9'($urandom), 17'($urandom), 1'b1);
        repeat (3) cyc(1'b0, 9'd0, 17'd0, 1'b1);
        chk("stream_throughput", 18'(q.size()), 18'd0);

        // random valid/ready traffic with small minuends to exercise borrows
        for (int n = 0; n < 200; n++)
            cyc(1'($urandom), 9'($urandom),
                ($urandom_range(0, 1) == 1) ? 17'($urandom_range(0, 600)) : 17'($urandom),
                1'($urandom));
        drain("drain_random");

        // three accepted, then 5-cycle stall from the first out_valid
        cyc(1'b1, 9'h010, 17'h00100, 1'b1);
        cyc(1'b1, 9'h0FF, 17'h00010, 1'b1);
        cyc(1'b1, 9'h123, 17'h0ABCD, 1'b1);
        chk("stall_first_valid", 18'(out_valid), 18'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 9'h1AA, 17'h00055, 1'b0);
            chk("stall_in_ready", 18'(in_ready), 18'd0);
            chk("stall_out_valid", 18'(out_valid), 18'd1);
            chk("stall_D", 18'(D), 18'(q[0][16:0]));
        end
        chk("stall_queue_len", 18'(q.size()), 18'd3);
        repeat (3) cyc(1'b0, 9'd0, 17'd0, 1'b1);
        chk("stall_release", 18'(q.size()), 18'd0);

        // reset with two items in flight and the output stalled
        cyc(1'b1, 9'h001, 17'h00003, 1'b1);
        cyc(1'b1, 9'h002, 17'h00004, 1'b1);
        cyc(1'b1, 9'h003, 17'h00005, 1'b1);
        cyc(1'b0, 9'd0, 17'd0, 1'b0);
        chk("prerst_out_valid", 18'(out_valid), 18'd1);
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_out_valid", 18'(out_valid), 18'd0);
        chk("rst2_D", 18'(D), 18'd0);
        chk("rst2_BO", 18'(BO), 18'd0);
        chk("rst2_in_ready", 18'(in_ready), 18'd1);
        q.delete();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 9'd0, 17'd0, 1'b1);
            chk("rst2_no_stale", 18'(out_valid), 18'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ub_bcl_sub_9_17.md
UB_BCL_SUB_9_17 -- requirements
Module: ub_bcl_sub_9_17

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; ports as follows (clock and reset first).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 X  input  9  unsigned subtrahend, zero-extended to 17 bits internally.
REQ-005 Y  input  17  unsigned minuend.
REQ-006 in_valid  input  1  X/Y valid this cycle.
REQ-007 in_ready  output  1  block accepts X/Y this cycle.
REQ-008 D  output  17  registered difference Y - X, modulo 2^17.
REQ-009 BO  output  1  borrow out; 1 iff Y < X.
REQ-010 out_valid  output  1  D/BO valid.
REQ-011 out_ready  input  1  consumer accepts D/BO this cycle.

Function
REQ-012 SHALL compute Y + ~Z + 1, with Z = {8'b0, X}, using block carry look-ahead: per-bit G = Y&~Z, P = Y^~Z; 4-bit blocks [3:0],[7:4],[11:8],[15:12] plus 1-bit block [16]; second level over the four 4-bit blocks, then the 1-bit block; carry-in constant 1.
REQ-013 BO SHALL equal the inverse of the level-2 carry out.
REQ-014 Pipeline SHALL have 3 register stages: S1 registers per-bit P and block G1/P1; S2 registers block carries C1[4:0] and final carry; S3 registers D, BO.
REQ-015 Latency SHALL be exactly 3 cycles from accepted input (in_valid&in_ready) to out_valid, with no stall.
REQ-016 Global advance enable en = !out_valid | out_ready; all stages and their valid bits SHALL update only when en=1.
REQ-017 in_ready SHALL equal en (combinational from out_valid, out_ready).
REQ-018 A stage with en=1 and no valid upstream SHALL load valid=0 (bubble); data registers hold their previous value when valid=0.
REQ-019 While out_valid=1 and out_ready=0, D, BO, out_valid and all internal stages SHALL hold unchanged; no input accepted.
REQ-020 Throughput SHALL be one result per cycle when out_ready stays high.
REQ-021 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-022 in_valid with in_ready=0 SHALL have no effect; the source holds X/Y.

Reset
REQ-023 With rst=1 at a rising edge, all stage valid bits, out_valid, D, BO and internal data registers SHALL become 0.
REQ-024 Reset SHALL take priority over en; in-flight operations are discarded, including a stalled output.
REQ-025 in_ready SHALL be 1 in the cycle after reset (out_valid=0).

Configuration
REQ-026 Macro UB_BCL_SUB_ZFLAG_EN defined: SHALL add output port ZF (1 bit), registered in S3 alongside D, = 1 iff D == 0; reset 0; holds under stall as D.
REQ-027 Macro UB_BCL_SUB_ZFLAG_EN undefined: ZF port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then X=9'h005, Y=17'h00012, in_valid one cycle, out_ready=1 -> 3 cycles later out_valid=1, D=17'h0000D, BO=0 (ZF=0 if enabled).
REQ-029 X=9'h1FF, Y=17'h00000 -> D=17'h1FE01, BO=1; X=9'h1FF, Y=17'h001FF -> D=0, BO=0, ZF=1 if enabled.
REQ-030 Back-to-back 100 random X/Y, out_ready=1 -> one result per cycle, each D/BO matching the 18-bit reference (Y - X) in order.
REQ-031 Three inputs accepted, out_ready=0 for 5 cycles from first out_valid -> in_ready=0 while stalled, D held, then three results in order once out_ready=1.
REQ-032 Block-boundary carry chains: Y=17'h10000, X=9'h001 -> D=17'h0FFFF, BO=0; Y=17'h00100, X=9'h001 -> D=17'h000FF.
REQ-033 rst asserted with 2 items in flight and out_valid=1 stalled -> next cycle out_valid=0, D=0, BO=0, in_ready=1; no stale result appears.
